// File: rtl/mm_fp_pkg.sv
// Shared definitions for the matrix result serializer: element geometry,
// E4M4 field widths and the stream state encoding.
package mm_fp_pkg;

    localparam int N_ELEM = 9;
    localparam int DATA_W = 8;
    localparam int EXP_W  = 4;
    localparam int MANT_W = 4;
    localparam int CODE_W = EXP_W + MANT_W;
    localparam int IDX_W  = 4;
    localparam int BUS_W  = N_ELEM * DATA_W;

    localparam logic [CODE_W-1:0] ZERO_CODE = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/matrix_fp_serializer_u8_to_e4m4.sv
// Unsigned 8-bit integer to E4M4 float: leading-one detect, normalise by
// shifting the leading one to the MSB, and keep the next MANT_W bits.
// Low bits below the mantissa window are truncated, not rounded.
module u8_to_e4m4
    import mm_fp_pkg::*;
(
    input  logic [DATA_W-1:0] i_value,
    output logic [CODE_W-1:0] o_code
);

    logic [2:0]        w_pos;
    logic [DATA_W-1:0] w_norm;
    logic [EXP_W-1:0]  w_exp;

    // Leading-one position; the highest set bit wins because it is seen last.
    always_comb begin
        w_pos = 3'd0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i_value[i]) begin
                w_pos = 3'(i);
            end
        end
    end

    // Normalise, build the exponent and pack the code; zero has its own code.
    always_comb begin
        w_norm = i_value << (3'd7 - w_pos);
        w_exp  = EXP_W'(w_pos) + EXP_W'(1);
        if (i_value == '0) begin
            o_code = ZERO_CODE;
        end else begin
            o_code = {w_exp, w_norm[DATA_W-2 -: MANT_W]};
        end
    end

endmodule

// File: rtl/matrix_fp_serializer.sv
// Snapshots the nine multiplier results on the rising edge of mm_done and
// streams them row-major as E4M4 floats over a valid/ready handshake.
// Handshake: an element transfers on a rising clk edge where fp_valid and
// fp_ready are both high; while fp_valid is high and fp_ready is low the
// outputs hold; fp_ready is ignored while fp_valid is low.
module matrix_fp_serializer
    import mm_fp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mm_done,
    input  logic [BUS_W-1:0]  mm_result,
    input  logic              fp_ready,
    output logic              fp_valid,
    output logic [CODE_W-1:0] fp_data,
    output logic [IDX_W-1:0]  fp_index,
    output logic [DATA_W-1:0] fp_raw,
    output logic              seq_done
);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_done_q;
    logic [BUS_W-1:0]    r_buf;
    logic                r_fp_valid;
    logic [CODE_W-1:0]   r_fp_data;
    logic [IDX_W-1:0]    r_fp_index;
    logic [DATA_W-1:0]   r_fp_raw;
    logic                r_seq_done;

    state_t              w_state_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_fp_valid_nxt;
    logic [CODE_W-1:0]   w_fp_data_nxt;
    logic [IDX_W-1:0]    w_fp_index_nxt;
    logic [DATA_W-1:0]   w_fp_raw_nxt;
    logic                w_seq_done_nxt;
    logic                w_capture;
    logic                w_start;
    logic [DATA_W-1:0]   w_cur;
    logic [CODE_W-1:0]   w_code;

    assign w_start = mm_done & ~r_done_q;
    assign w_cur   = r_buf[{r_idx, 3'b000} +: DATA_W];

    u8_to_e4m4 u_conv (
        .i_value (w_cur),
        .o_code  (w_code)
    );

    // Next-state and next-output decode for the stream sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_fp_valid_nxt = r_fp_valid;
        w_fp_data_nxt  = r_fp_data;
        w_fp_index_nxt = r_fp_index;
        w_fp_raw_nxt   = r_fp_raw;
        w_seq_done_nxt = r_seq_done;
        w_capture      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                w_fp_data_nxt  = w_code;
                w_fp_raw_nxt   = w_cur;
                w_fp_index_nxt = r_idx;
                w_fp_valid_nxt = 1'b1;
                w_state_nxt    = OUT;
            end
            OUT: begin
                if (r_fp_valid && fp_ready) begin
                    w_fp_valid_nxt = 1'b0;
                    if (r_idx == IDX_W'(N_ELEM - 1)) begin
                        w_seq_done_nxt = 1'b1;
                        w_state_nxt    = DONE;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = CONV;
                    end
                end
            end
            DONE: begin
                if (!mm_done) begin
                    w_seq_done_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, index, edge-detect and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_done_q   <= 1'b0;
            r_fp_valid <= 1'b0;
            r_fp_data  <= '0;
            r_fp_index <= '0;
            r_fp_raw   <= '0;
            r_seq_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_done_q   <= mm_done;
            r_fp_valid <= w_fp_valid_nxt;
            r_fp_data  <= w_fp_data_nxt;
            r_fp_index <= w_fp_index_nxt;
            r_fp_raw   <= w_fp_raw_nxt;
            r_seq_done <= w_seq_done_nxt;
        end
    end

    // Result snapshot; later changes on mm_result do not reach the stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf <= '0;
        end else if (w_capture) begin
            r_buf <= mm_result;
        end
    end

    assign fp_valid = r_fp_valid;
    assign fp_data  = r_fp_data;
    assign fp_index = r_fp_index;
    assign fp_raw   = r_fp_raw;
    assign seq_done = r_seq_done;

endmodule

// File: tb/tb_matrix_fp_serializer.sv
// Bench for matrix_fp_serializer: directed scenarios plus randomized
// matrices, checked against an arithmetic E4M4 model and an expected queue.
module tb_matrix_fp_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mm_done;
  logic [71:0] mm_result;
  logic        fp_ready;
  logic        fp_valid;
  logic [7:0]  fp_data;
  logic [3:0]  fp_index;
  logic [7:0]  fp_raw;
  logic        seq_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] raw_q[$];

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_fp_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .mm_done   (mm_done),
    .mm_result (mm_result),
    .fp_ready  (fp_ready),
    .fp_valid  (fp_valid),
    .fp_data   (fp_data),
    .fp_index  (fp_index),
    .fp_raw    (fp_raw),
    .seq_done  (seq_done)
  );

  // reference: value = 1.mant * 2^p, exp = p+1, mant = floor(v*16/2^p) - 16
  function automatic logic [7:0] model_e4m4(input int v);
    int p;
    int m;
    if (v == 0) return 8'h00;
    p = 0;
    while ((v >> (p + 1)) != 0) p++;
    m = ((v * 16) >> p) - 16;
    return 8'((p + 1) * 16 + m);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [71:0] rand_matrix();
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // driver + scoreboard for one full sequence
  task automatic run_seq(input logic [71:0] res, input int stall_k, input int stall_n,
                         input bit hold, input bit change_mid, input bit check_lat);
    int c0;
    int wait_n;
    logic [7:0] exp_code;
    logic [7:0] exp_raw;
    mm_done = 1'b0;
    step();
    step();
    exp_q.delete();
    raw_q.delete();
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(model_e4m4(int'(res[8*k +: 8])));
      raw_q.push_back(res[8*k +: 8]);
    end
    mm_result = res;
    mm_done   = 1'b1;
    c0 = cyc;
    step();
    if (!hold) mm_done = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_n = 0;
      while (fp_valid !== 1'b1 && wait_n < 8) begin
        step();
        wait_n++;
      end
      check("valid_rise", fp_valid, 1);
      exp_code = exp_q.pop_front();
      exp_raw  = raw_q.pop_front();
      check("fp_index", fp_index, k);
      check("fp_data", fp_data, exp_code);
      check("fp_raw", fp_raw, exp_raw);
      if (k == stall_k) begin
        fp_ready = 1'b0;
        repeat (stall_n) begin
          step();
          check("stall_valid", fp_valid, 1);
          check("stall_data", fp_data, exp_code);
          check("stall_index", fp_index, k);
        end
        fp_ready = 1'b1;
      end
      if (k == 8) check("seq_done_early", seq_done, 0);
      step();
      if (change_mid && k == 2) mm_result = ~res;
      if (change_mid && !hold && k == 4) mm_done = 1'b1;
      if (change_mid && !hold && k == 5) mm_done = 1'b0;
      if (k < 8) begin
        check("valid_drop", fp_valid, 0);
      end else begin
        check("seq_done_rise", seq_done, 1);
        if (check_lat) check("latency", cyc - c0 - 1, 18);
      end
    end
  endtask

  initial begin
    logic [71:0] res;
    int vals[9];
    int wait_n;
    reset     = 1'b0;
    mm_done   = 1'b0;
    mm_result = '0;
    fp_ready  = 1'b1;
    #1;
    check("rst_valid", fp_valid, 0);
    check("rst_data", fp_data, 0);
    check("rst_index", fp_index, 0);
    check("rst_raw", fp_raw, 0);
    check("rst_seq_done", seq_done, 0);
    repeat (3) step();
    reset = 1'b1;
    step();

    // ascending 0..8, pulsed mm_done, latency check
    for (int k = 0; k < 9; k++) res[8*k +: 8] = 8'(k);
    run_seq(res, -1, 0, 0, 0, 1);
    step();
    check("pulse_seq_done_fall", seq_done, 0);

    // truncation / boundary values
    vals = '{255, 200, 1, 3, 128, 0, 15, 16, 17};
    for (int k = 0; k < 9; k++) res[8*k +: 8] = 8'(vals[k]);
    run_seq(res, -1, 0, 0, 0, 1);

    // backpressure on element 4
    run_seq(rand_matrix(), 4, 5, 0, 0, 0);

    // mm_done held high: single sequence, seq_done held, then re-raise
    run_seq(rand_matrix(), -1, 0, 1, 0, 1);
    repeat (100) begin
      step();
      check("hold_seq_done", seq_done, 1);
      check("hold_no_valid", fp_valid, 0);
    end
    mm_done = 1'b0;
    step();
    check("drop_seq_done", seq_done, 0);
    run_seq(rand_matrix(), -1, 0, 1, 0, 1);
    mm_done = 1'b0;

    // mm_result changes and mm_done re-pulse during the stream
    run_seq(rand_matrix(), -1, 0, 0, 1, 1);
    repeat (4) begin
      step();
      check("no_retrigger", fp_valid, 0);
    end

    // async reset while element 3 is presented
    mm_done = 1'b0;
    step();
    step();
    mm_result = rand_matrix();
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
    wait_n = 0;
    while (!(fp_valid === 1'b1 && fp_index === 4'd3) && wait_n < 40) begin
      step();
      wait_n++;
    end
    check("pre_reset_index", fp_index, 3);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", fp_valid, 0);
    check("mid_rst_data", fp_data, 0);
    check("mid_rst_index", fp_index, 0);
    check("mid_rst_raw", fp_raw, 0);
    check("mid_rst_seq_done", seq_done, 0);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    check("post_rst_idle", fp_valid, 0);
    run_seq(rand_matrix(), -1, 0, 0, 0, 1);

    // randomized matrices with random stalls
    for (int t = 0; t < 6; t++) begin
      run_seq(rand_matrix(), $urandom_range(0, 8), $urandom_range(0, 4), 0, 0, 0);
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
